shift_right_unit: RTL and testbench

SHIFT_RIGHT_UNIT -- requirements
Module: shift_right_unit

---
 rtl/shift_pkg.sv | 8 +
 rtl/shift_counter.sv | 18 +
 rtl/shift_right_unit.sv | 45 ++++
 tb/tb_shift_right_unit.sv | 123 ++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared state encoding, width defaults and shift-op encoding
package shift_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int SHAMT_W_DEF = 5;
  localparam logic OP_SRL = 1'b0;
  localparam logic OP_SRA = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_counter.sv
// shift_counter: loadable down-counter tracking remaining shift steps
module shift_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] din,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (!reset) count <= '0;
    else if (load) count <= din;
    else if (dec) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/shift_right_unit.sv
// shift_right_unit: multicycle SRL/SRA, one bit per cycle, with flush abort
module shift_right_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               arith,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);
  state_t state;
  logic [WIDTH-1:0] work;
  logic fill, zero, accept, step;
  assign accept = !flush && start && state != SHIFT;
  assign step = !flush && state == SHIFT && !zero;
  assign busy = state == SHIFT;
  assign done = state == DONE;
  shift_counter #(.W(SHAMT_W)) u_cnt (
    .clk(clk), .reset(reset), .load(accept), .dec(step), .din(shamt), .zero(zero)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      work <= '0;
      fill <= 1'b0;
      data_out <= '0;
    end else if (flush) state <= IDLE;
    else if (accept) begin
      work <= data_in;
      fill <= (arith == OP_SRA) & data_in[WIDTH-1];
      state <= SHIFT;
    end else if (step) work <= {fill, work[WIDTH-1:1]};
    else if (state == SHIFT) begin
      data_out <= work;
      state <= DONE;
    end else state <= IDLE;
endmodule

// File: tb/tb_shift_right_unit.sv
// tb_shift_right_unit: directed checks of shift results, latency, flush and reset
module tb_shift_right_unit;
  logic clk = 0, reset = 0, start = 0, arith = 0, flush = 0;
  logic [31:0] data_in = '0;
  logic [4:0] shamt = '0;
  logic busy, done;
  logic [31:0] data_out;
  int vectors = 0, miscompares = 0;

  shift_right_unit dut (
    .clk(clk), .reset(reset), .start(start), .arith(arith), .data_in(data_in),
    .shamt(shamt), .flush(flush), .busy(busy), .done(done), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic a, input logic [31:0] d, input logic [4:0] s);
    start = 1; arith = a; data_in = d; shamt = s;
    tick();
    start = 0; data_in = 32'hDEAD_BEEF; shamt = 5'd17; arith = ~a;
  endtask

  task automatic wait_done(input string tag, input int cycles, input logic [31:0] exp);
    int n = 0, b = 0;
    while (!done && n < 40) begin
      if (busy) b++;
      tick();
      n++;
    end
    check({tag, "_latency"}, n, cycles);
    check({tag, "_busy_cycles"}, b, cycles);
    check({tag, "_data"}, data_out, exp);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tick(); tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_data", data_out, 32'd0);
    reset = 1;
    tick();
    launch(1'b0, 32'hF000_0000, 5'd4);
    wait_done("srl4", 5, 32'h0F00_0000);
    tick();
    check("done_pulse_ends", {31'd0, done}, 32'd0);
    check("data_held", data_out, 32'h0F00_0000);
    launch(1'b1, 32'h8000_0000, 5'd31);
    wait_done("sra31", 32, 32'hFFFF_FFFF);
    tick();
    launch(1'b0, 32'h8000_0000, 5'd31);
    wait_done("srl31", 32, 32'h0000_0001);
    tick();
    launch(1'b0, 32'h1234_5678, 5'd0);
    wait_done("sh0", 1, 32'h1234_5678);
    tick();
    launch(1'b1, 32'h8765_4321, 5'd3);
    wait_done("sra3", 4, 32'hF0EC_A864);
    tick();
    launch(1'b0, 32'hF000_0000, 5'd4);
    wait_done("srl4b", 5, 32'h0F00_0000);
    tick();
    launch(1'b1, 32'h8000_0000, 5'd10);
    start = 1; data_in = 32'h0000_00FF; shamt = 5'd0;
    tick();
    start = 0;
    check("start_ignored_busy", {31'd0, busy}, 32'd1);
    tick();
    check("start_ignored_done", {31'd0, done}, 32'd0);
    flush = 1;
    tick();
    flush = 0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_data", data_out, 32'h0F00_0000);
    repeat (12) begin
      tick();
      check("flush_no_done", {31'd0, done}, 32'd0);
    end
    check("flush_data_late", data_out, 32'h0F00_0000);
    start = 1; flush = 1; data_in = 32'hFFFF_0000; shamt = 5'd2;
    tick();
    start = 0; flush = 0;
    check("flush_blocks_start", {31'd0, busy}, 32'd0);
    launch(1'b0, 32'hAAAA_AAAA, 5'd6);
    tick();
    reset = 0;
    tick();
    reset = 1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_data", data_out, 32'd0);
    launch(1'b1, 32'hFFFF_FF00, 5'd8);
    wait_done("post_reset_sra8", 9, 32'hFFFF_FFFF);
    tick();
    launch(1'b0, 32'h0000_00F0, 5'd4);
    wait_done("b2b_first", 5, 32'h0000_000F);
    start = 1; arith = 1'b1; data_in = 32'h8000_0000; shamt = 5'd1;
    tick();
    start = 0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    check("b2b_data_kept", data_out, 32'h0000_000F);
    wait_done("b2b_second", 2, 32'hC000_0000);
    tick();
    check("final_idle", {30'd0, busy, done}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
